phys_reg_free_list: RTL and testbench

- Circular FIFO of free physical register tags, NUM_PHYS_REGS - NUM_ARCH_REGS deep.
- Sits directly upstream of dispatch/rename: supplies a new dest phys reg tag each time an instruction with reg_write dispatches.
- Refilled by the ROB at commit with the safe_dest_phys_reg_tag being retired.
- Holds CHECKPOINT_COLUMNS saved head pointers so a BRU mispredict restores the list in one cycle.

---
 rtl/free_list_if.sv | 35 +++
 rtl/phys_reg_free_list.sv | 87 ++++++++
 tb/tb_phys_reg_free_list.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
// Dispatch, ROB commit and checkpoint signals for the physical register free list.
// The master side drives the requests and the slave side is the free list itself.
interface free_list_if #(
  parameter int PHYS_REG_WIDTH = 6,
  parameter int PTR_W          = 6,
  parameter int CKPT_W         = 2
);
  logic                      dequeue_valid;
  logic [PHYS_REG_WIDTH-1:0] dequeue_phys_reg_tag;
  logic                      dequeue_req;
  logic                      enqueue_valid;
  logic [PHYS_REG_WIDTH-1:0] enqueue_phys_reg_tag;
  logic                      save_checkpoint_valid;
  logic [CKPT_W-1:0]         save_checkpoint_column;
  logic                      restore_checkpoint_valid;
  logic [CKPT_W-1:0]         restore_checkpoint_column;
  logic                      empty;
  logic                      full;
  logic [PTR_W-1:0]          count;
  logic                      overflow_error;

  modport master (
    output dequeue_req, enqueue_valid, enqueue_phys_reg_tag,
           save_checkpoint_valid, save_checkpoint_column,
           restore_checkpoint_valid, restore_checkpoint_column,
    input  dequeue_valid, dequeue_phys_reg_tag, empty, full, count, overflow_error
  );

  modport slave (
    input  dequeue_req, enqueue_valid, enqueue_phys_reg_tag,
           save_checkpoint_valid, save_checkpoint_column,
           restore_checkpoint_valid, restore_checkpoint_column,
    output dequeue_valid, dequeue_phys_reg_tag, empty, full, count, overflow_error
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags feeding rename, refilled at commit,
// with saved head pointers so a mispredict rolls the list back in one cycle.
module phys_reg_free_list #(
  parameter int FREE_LIST_DEPTH     = 32,
  parameter int LOG_FREE_LIST_DEPTH = 5,
  parameter int NUM_PHYS_REGS       = 64,
  parameter int CHECKPOINT_COLUMNS  = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  free_list_if.slave fl
);
  localparam int PHYS_REG_WIDTH = $clog2(NUM_PHYS_REGS);
  localparam int PTR_W          = LOG_FREE_LIST_DEPTH + 1;

  logic [PHYS_REG_WIDTH-1:0] entries    [FREE_LIST_DEPTH];
  logic [PTR_W-1:0]          checkpoint [CHECKPOINT_COLUMNS];
  logic [PTR_W-1:0]          head;
  logic [PTR_W-1:0]          tail;
  logic                      overflow_q;

  logic [PTR_W-1:0] occupancy;
  logic [PTR_W-1:0] head_next;
  logic [PTR_W-1:0] tail_next;
  logic [PTR_W-1:0] restore_head;
  logic [PTR_W-1:0] restore_occupancy;
  logic             is_empty;
  logic             is_full;
  logic             deq_fire;
  logic             enq_fire;
  logic             overflow_set;

  // Pointers carry a wrap bit, so plain modular subtraction yields the occupancy.
  always_comb begin
    occupancy         = tail - head;
    is_empty          = (occupancy == '0);
    is_full           = (occupancy == PTR_W'(FREE_LIST_DEPTH));
    deq_fire          = fl.dequeue_req && !is_empty && !fl.restore_checkpoint_valid;
    enq_fire          = fl.enqueue_valid && !is_full;
    restore_head      = checkpoint[fl.restore_checkpoint_column];
    tail_next         = enq_fire ? tail + PTR_W'(1) : tail;
    head_next         = head;
    if (fl.restore_checkpoint_valid) begin
      head_next = restore_head;
    end else if (deq_fire) begin
      head_next = head + PTR_W'(1);
    end
    // A rollback is judged against the tail that will coexist with the restored head.
    restore_occupancy = tail_next - restore_head;
    overflow_set      = (fl.enqueue_valid && is_full) ||
                        (fl.restore_checkpoint_valid &&
                         (restore_occupancy > PTR_W'(FREE_LIST_DEPTH)));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
        entries[i] <= PHYS_REG_WIDTH'(FREE_LIST_DEPTH + i);
      end
      for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
        checkpoint[c] <= '0;
      end
      head       <= '0;
      tail       <= PTR_W'(FREE_LIST_DEPTH);
      overflow_q <= 1'b0;
    end else begin
      if (enq_fire) begin
        entries[tail[LOG_FREE_LIST_DEPTH-1:0]] <= fl.enqueue_phys_reg_tag;
      end
      if (fl.save_checkpoint_valid && !fl.restore_checkpoint_valid) begin
        checkpoint[fl.save_checkpoint_column] <= head_next;
      end
      head <= head_next;
      tail <= tail_next;
      if (overflow_set) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign fl.dequeue_valid        = !is_empty;
  assign fl.dequeue_phys_reg_tag = entries[head[LOG_FREE_LIST_DEPTH-1:0]];
  assign fl.empty                = is_empty;
  assign fl.full                 = is_full;
  assign fl.count                = occupancy;
  assign fl.overflow_error       = overflow_q;
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: vector table, directed corner sequences and
// random traffic against an integer-pointer reference model.
module tb_phys_reg_free_list;
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  free_list_if fl ();

  phys_reg_free_list dut (
    .CLK  (CLK),
    .nRST (nRST),
    .fl   (fl)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: free list as plain integers, pointers taken modulo 64.
  int m_mem [32];
  int m_ckpt[4];
  int m_head;
  int m_tail;
  bit m_ovf;

  typedef struct {
    bit deq; bit enq; int etag; bit sv; int svc; bit rs; int rsc;
    int e_tag; int e_count; bit e_valid; bit e_full; bit e_empty; bit e_ovf;
  } vec_t;
  vec_t vecs[14];

  function automatic int m_count();
    return (m_tail - m_head + 64) % 64;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32 + i;
    for (int c = 0; c < 4; c++) m_ckpt[c] = 0;
    m_head = 0;
    m_tail = 32;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_step(bit deq, bit enq, int etag, bit sv, int svc, bit rs, int rsc);
    int  cnt      = m_count();
    int  new_head = m_head;
    int  new_tail = m_tail;
    bit  took     = deq && (cnt != 0) && !rs;
    if (rs) new_head = m_ckpt[rsc];
    else if (took) new_head = (m_head + 1) % 64;
    if (enq) begin
      if (cnt == 32) m_ovf = 1'b1;
      else begin
        m_mem[m_tail % 32] = etag;
        new_tail = (m_tail + 1) % 64;
      end
    end
    if (sv && !rs) m_ckpt[svc] = new_head;
    if (rs && ((new_tail - new_head + 64) % 64) > 32) m_ovf = 1'b1;
    m_head = new_head;
    m_tail = new_tail;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive(input bit deq, input bit enq, input int etag,
                       input bit sv, input int svc, input bit rs, input int rsc);
    fl.dequeue_req               = deq;
    fl.enqueue_valid             = enq;
    fl.enqueue_phys_reg_tag      = 6'(etag);
    fl.save_checkpoint_valid     = sv;
    fl.save_checkpoint_column    = 2'(svc);
    fl.restore_checkpoint_valid  = rs;
    fl.restore_checkpoint_column = 2'(rsc);
  endtask

  task automatic cyc(input bit deq, input bit enq, input int etag,
                     input bit sv, input int svc, input bit rs, input int rsc);
    drive(deq, enq, etag, sv, svc, rs, rsc);
    @(posedge CLK);
    model_step(deq, enq, etag, sv, svc, rs, rsc);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_tag"},   32'(fl.dequeue_phys_reg_tag), 32'(m_mem[m_head % 32]));
    chk({tag, "_count"}, 32'(fl.count), 32'(m_count()));
    chk({tag, "_valid"}, 32'(fl.dequeue_valid), 32'(m_count() != 0));
    chk({tag, "_full"},  32'(fl.full), 32'(m_count() == 32));
    chk({tag, "_empty"}, 32'(fl.empty), 32'(m_count() == 0));
    chk({tag, "_ovf"},   32'(fl.overflow_error), 32'(m_ovf));
  endtask

  task automatic rand_block(input int cycles, input int rs_pct);
    for (int n = 0; n < cycles; n++) begin
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom_range(0, 63),
          $urandom_range(0, 99) < 30, $urandom_range(0, 3),
          $urandom_range(0, 99) < rs_pct, $urandom_range(0, 3));
      chk_model("rand");
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;

    // Reset state
    do_reset();
    chk("rst_count", 32'(fl.count), 32);
    chk("rst_full",  32'(fl.full), 1);
    chk("rst_empty", 32'(fl.empty), 0);
    chk("rst_valid", 32'(fl.dequeue_valid), 1);
    chk("rst_tag",   32'(fl.dequeue_phys_reg_tag), 32);
    chk("rst_ovf",   32'(fl.overflow_error), 0);

    // Drain, ignored dequeue on empty, refill across the index wrap
    for (int i = 0; i < 32; i++) begin
      chk("drain_tag", 32'(fl.dequeue_phys_reg_tag), 32'(32 + i));
      cyc(1, 0, 0, 0, 0, 0, 0);
    end
    chk("drain_empty", 32'(fl.empty), 1);
    chk("drain_valid", 32'(fl.dequeue_valid), 0);
    chk("drain_count", 32'(fl.count), 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("deq_empty_count", 32'(fl.count), 0);
    chk("deq_empty_empty", 32'(fl.empty), 1);
    chk("deq_empty_ovf",   32'(fl.overflow_error), 0);
    cyc(0, 1, 5, 0, 0, 0, 0);
    cyc(0, 1, 9, 0, 0, 0, 0);
    cyc(0, 1, 7, 0, 0, 0, 0);
    chk("wrap_count", 32'(fl.count), 3);
    chk("wrap_tag0",  32'(fl.dequeue_phys_reg_tag), 5);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("wrap_tag1",  32'(fl.dequeue_phys_reg_tag), 9);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("wrap_tag2",  32'(fl.dequeue_phys_reg_tag), 7);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("wrap_empty", 32'(fl.empty), 1);
    chk("nobypass_valid_before", 32'(fl.dequeue_valid), 0);
    cyc(1, 1, 12, 0, 0, 0, 0);
    chk("nobypass_valid_after", 32'(fl.dequeue_valid), 1);
    chk("nobypass_tag",   32'(fl.dequeue_phys_reg_tag), 12);
    chk("nobypass_count", 32'(fl.count), 1);

    // Checkpoint save/restore table
    vecs[0]  = '{1,0,0, 0,0, 0,0, 33,31,1,0,0,0};
    vecs[1]  = '{1,0,0, 0,0, 0,0, 34,30,1,0,0,0};
    vecs[2]  = '{1,0,0, 1,1, 0,0, 35,29,1,0,0,0};
    vecs[3]  = '{1,0,0, 0,0, 0,0, 36,28,1,0,0,0};
    vecs[4]  = '{1,0,0, 0,0, 0,0, 37,27,1,0,0,0};
    vecs[5]  = '{1,0,0, 0,0, 0,0, 38,26,1,0,0,0};
    vecs[6]  = '{1,0,0, 0,0, 0,0, 39,25,1,0,0,0};
    vecs[7]  = '{1,0,0, 0,0, 1,1, 35,29,1,0,0,0};
    vecs[8]  = '{0,1,8, 0,0, 0,0, 35,30,1,0,0,0};
    vecs[9]  = '{1,1,20,0,0, 0,0, 36,30,1,0,0,0};
    vecs[10] = '{0,0,0, 0,0, 1,1, 35,31,1,0,0,0};
    vecs[11] = '{1,0,0, 1,3, 0,0, 36,30,1,0,0,0};
    vecs[12] = '{0,0,0, 0,0, 1,3, 36,30,1,0,0,0};
    vecs[13] = '{0,0,0, 0,0, 1,0,  8,34,1,0,0,1};
    do_reset();
    for (int v = 0; v < 14; v++) begin
      cyc(vecs[v].deq, vecs[v].enq, vecs[v].etag, vecs[v].sv, vecs[v].svc, vecs[v].rs, vecs[v].rsc);
      chk($sformatf("vec%0d_tag", v),   32'(fl.dequeue_phys_reg_tag), 32'(vecs[v].e_tag));
      chk($sformatf("vec%0d_count", v), 32'(fl.count), 32'(vecs[v].e_count));
      chk($sformatf("vec%0d_valid", v), 32'(fl.dequeue_valid), 32'(vecs[v].e_valid));
      chk($sformatf("vec%0d_full", v),  32'(fl.full), 32'(vecs[v].e_full));
      chk($sformatf("vec%0d_empty", v), 32'(fl.empty), 32'(vecs[v].e_empty));
      chk($sformatf("vec%0d_ovf", v),   32'(fl.overflow_error), 32'(vecs[v].e_ovf));
    end

    // Overflow while full, including with a same-cycle dequeue, and its stickiness
    do_reset();
    cyc(0, 1, 8, 0, 0, 0, 0);
    chk("ovf_count", 32'(fl.count), 32);
    chk("ovf_flag",  32'(fl.overflow_error), 1);
    chk("ovf_tag",   32'(fl.dequeue_phys_reg_tag), 32);
    cyc(1, 1, 8, 0, 0, 0, 0);
    chk("ovf_deq_count", 32'(fl.count), 31);
    chk("ovf_deq_tag",   32'(fl.dequeue_phys_reg_tag), 33);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("ovf_sticky", 32'(fl.overflow_error), 1);
    do_reset();
    chk("ovf_cleared", 32'(fl.overflow_error), 0);

    // Enqueue, dequeue and save together at count 10
    for (int i = 0; i < 22; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    chk("sim_pre_count", 32'(fl.count), 10);
    chk("sim_pre_tag",   32'(fl.dequeue_phys_reg_tag), 54);
    cyc(1, 1, 3, 1, 2, 0, 0);
    chk("sim_count", 32'(fl.count), 10);
    chk("sim_tag",   32'(fl.dequeue_phys_reg_tag), 55);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 2);
    chk("sim_restore_tag",   32'(fl.dequeue_phys_reg_tag), 55);
    chk("sim_restore_count", 32'(fl.count), 10);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    chk("sim_written_tag", 32'(fl.dequeue_phys_reg_tag), 3);
    chk("sim_final_count", 32'(fl.count), 1);

    // Random traffic against the model, with an asynchronous reset mid-run
    do_reset();
    rand_block(250, 2);
    #2 nRST = 1'b0;
    #1;
    chk("async_rst_count", 32'(fl.count), 32);
    chk("async_rst_tag",   32'(fl.dequeue_phys_reg_tag), 32);
    chk("async_rst_ovf",   32'(fl.overflow_error), 0);
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    rand_block(250, 4);
    do_reset();
    rand_block(200, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
